// File: rtl/dma_pkg.sv
// Shared types and constants for the dma_m AXI4 copy engine.
// Also supplies the `AXI_* width defines when the surrounding build has not.

`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_FIN
    } dma_m_state_e;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int DMA_4K_WORDS = 1024;

    // Beats for the next burst: limited by words remaining, buffer depth and
    // the distance of either address to its next 4 KB page.
    function automatic logic [4:0] dma_calc_beats(
        input logic [15:0] rem,
        input logic [9:0]  src_word,
        input logic [9:0]  dst_word,
        input logic [4:0]  depth
    );
        logic [16:0] b;
        logic [16:0] s_room;
        logic [16:0] d_room;
        b      = {1'b0, rem};
        s_room = 17'(DMA_4K_WORDS) - {7'd0, src_word};
        d_room = 17'(DMA_4K_WORDS) - {7'd0, dst_word};
        if ({12'd0, depth} < b) b = {12'd0, depth};
        if (s_room < b) b = s_room;
        if (d_room < b) b = d_room;
        return 5'(b);
    endfunction

endpackage

// File: rtl/dma_m_buf.sv
// Burst buffer for dma_m: DEPTH x data-width register file,
// one synchronous write port and one asynchronous read port.

module dma_m_buf
    import dma_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic                      ACLK,
    input  logic                      we,
    input  logic [IDX_W-1:0]          waddr,
    input  logic [`AXI_DATA_BITS-1:0] wdata,
    input  logic [IDX_W-1:0]          raddr,
    output logic [`AXI_DATA_BITS-1:0] rdata
);

    logic [`AXI_DATA_BITS-1:0] mem [DEPTH];

    // Write one read-data beat into its slot.
    always_ff @(posedge ACLK) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/dma_m.sv
// dma_m: AXI4 master copy engine. Reads INCR bursts from src, buffers them,
// writes them to dst, repeats until word_cnt words are moved, pulses done.
// Optional feature macro: DMA_M_RESP_CHECK_EN (adds the err port and
// aborts the copy on a non-OKAY read or write response).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_AR    | read address presented, waiting for ARREADY_M
// ST_R     | accepting read beats into the buffer until RLAST_M
// ST_AW    | write address presented, waiting for AWREADY_M
// ST_W     | streaming buffer out on W until the last beat is accepted
// ST_B     | waiting for the write response, then next burst or finish
// ST_FIN   | done pulse, back to idle

module dma_m
    import dma_pkg::*;
#(
    parameter int                      BUF_DEPTH = 16,
    parameter logic [`AXI_ID_BITS-1:0] M_ID      = 4'd0
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       start,
    input  logic [`AXI_ADDR_BITS-1:0]  src_addr,
    input  logic [`AXI_ADDR_BITS-1:0]  dst_addr,
    input  logic [15:0]                word_cnt,
    output logic                       busy,
    output logic                       done,
`ifdef DMA_M_RESP_CHECK_EN
    output logic                       err,
`endif
    output logic [`AXI_ID_BITS-1:0]    ARID_M,
    output logic [`AXI_ADDR_BITS-1:0]  ARADDR_M,
    output logic [`AXI_LEN_BITS-1:0]   ARLEN_M,
    output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M,
    output logic [`AXI_BURST_BITS-1:0] ARBURST_M,
    output logic                       ARVALID_M,
    input  logic                       ARREADY_M,
    input  logic [`AXI_ID_BITS-1:0]    RID_M,
    input  logic [`AXI_DATA_BITS-1:0]  RDATA_M,
    input  logic [`AXI_RESP_BITS-1:0]  RRESP_M,
    input  logic                       RLAST_M,
    input  logic                       RVALID_M,
    output logic                       RREADY_M,
    output logic [`AXI_ID_BITS-1:0]    AWID_M,
    output logic [`AXI_ADDR_BITS-1:0]  AWADDR_M,
    output logic [`AXI_LEN_BITS-1:0]   AWLEN_M,
    output logic [`AXI_SIZE_BITS-1:0]  AWSIZE_M,
    output logic [`AXI_BURST_BITS-1:0] AWBURST_M,
    output logic                       AWVALID_M,
    input  logic                       AWREADY_M,
    output logic [`AXI_DATA_BITS-1:0]  WDATA_M,
    output logic [`AXI_STRB_BITS-1:0]  WSTRB_M,
    output logic                       WLAST_M,
    output logic                       WVALID_M,
    input  logic                       WREADY_M,
    input  logic [`AXI_ID_BITS-1:0]    BID_M,
    input  logic [`AXI_RESP_BITS-1:0]  BRESP_M,
    input  logic                       BVALID_M,
    output logic                       BREADY_M
);

    localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef logic [`AXI_ADDR_BITS-1:0] addr_t;
    typedef logic [`AXI_LEN_BITS-1:0]  len_t;
    typedef logic [IDX_W-1:0]          idx_t;

    dma_m_state_e state;
    addr_t        src;
    addr_t        dst;
    logic [15:0]  rem;
    logic [4:0]   beats;
    idx_t         ridx;
    idx_t         widx;
    logic         rerr;
    logic         err_q;

    logic [4:0]   start_beats;
    logic [4:0]   next_beats;
    addr_t        burst_bytes;
    addr_t        src_nxt;
    addr_t        dst_nxt;
    logic [15:0]  rem_nxt;
    addr_t        src_al;
    addr_t        dst_al;
    logic         r_bad;
    logic         b_bad;
    logic         w_last_beat;
    logic         buf_we;
    logic [`AXI_DATA_BITS-1:0] buf_rdata;
    logic         unused_sigs;

    assign src_al      = {src_addr[`AXI_ADDR_BITS-1:2], 2'b00};
    assign dst_al      = {dst_addr[`AXI_ADDR_BITS-1:2], 2'b00};
    assign burst_bytes = addr_t'({beats, 2'b00});
    assign src_nxt     = src + burst_bytes;
    assign dst_nxt     = dst + burst_bytes;
    assign rem_nxt     = rem - {11'd0, beats};
    assign start_beats = dma_calc_beats(word_cnt, src_al[11:2], dst_al[11:2], 5'(BUF_DEPTH));
    assign next_beats  = dma_calc_beats(rem_nxt, src_nxt[11:2], dst_nxt[11:2], 5'(BUF_DEPTH));
    assign w_last_beat = (5'(widx) == (beats - 5'd1));

`ifdef DMA_M_RESP_CHECK_EN
    assign r_bad = (RRESP_M != AXI_RESP_OKAY);
    assign b_bad = (BRESP_M != AXI_RESP_OKAY);
    assign err   = err_q;
`else
    assign r_bad = 1'b0;
    assign b_bad = 1'b0;
`endif

    // IDs are not tracked: the engine only ever has one transaction in flight.
    assign unused_sigs = ^{RID_M, BID_M, RRESP_M, BRESP_M,
                           src_addr[1:0], dst_addr[1:0], err_q};

    assign ARID_M  = M_ID;
    assign AWID_M  = M_ID;
    assign busy    = (state != ST_IDLE);
    assign buf_we  = (state == ST_R) && RVALID_M && RREADY_M;
    // W payload is forced to zero outside a burst so reset leaves it clean.
    assign WDATA_M = WVALID_M ? buf_rdata : '0;
    assign WSTRB_M = WVALID_M ? '1 : '0;
    assign WLAST_M = WVALID_M && w_last_beat;

    dma_m_buf #(
        .DEPTH (BUF_DEPTH),
        .IDX_W (IDX_W)
    ) u_buf (
        .ACLK  (ACLK),
        .we    (buf_we),
        .waddr (ridx),
        .wdata (RDATA_M),
        .raddr (widx),
        .rdata (buf_rdata)
    );

    // Sequencer: state, copy bookkeeping and all registered channel outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            src       <= '0;
            dst       <= '0;
            rem       <= '0;
            beats     <= '0;
            ridx      <= '0;
            widx      <= '0;
            rerr      <= 1'b0;
            err_q     <= 1'b0;
            done      <= 1'b0;
            ARADDR_M  <= '0;
            ARLEN_M   <= '0;
            ARSIZE_M  <= '0;
            ARBURST_M <= '0;
            ARVALID_M <= 1'b0;
            RREADY_M  <= 1'b0;
            AWADDR_M  <= '0;
            AWLEN_M   <= '0;
            AWSIZE_M  <= '0;
            AWBURST_M <= '0;
            AWVALID_M <= 1'b0;
            WVALID_M  <= 1'b0;
            BREADY_M  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        rerr  <= 1'b0;
                        if (word_cnt == 16'd0) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            src       <= src_al;
                            dst       <= dst_al;
                            rem       <= word_cnt;
                            beats     <= start_beats;
                            ridx      <= '0;
                            widx      <= '0;
                            ARADDR_M  <= src_al;
                            ARLEN_M   <= len_t'(start_beats - 5'd1);
                            ARSIZE_M  <= AXI_SIZE_WORD;
                            ARBURST_M <= AXI_BURST_INCR;
                            ARVALID_M <= 1'b1;
                            state     <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (ARREADY_M) begin
                        ARVALID_M <= 1'b0;
                        RREADY_M  <= 1'b1;
                        state     <= ST_R;
                    end
                end
                ST_R: begin
                    if (RVALID_M) begin
                        ridx <= ridx + idx_t'(1);
                        if (r_bad) begin
                            rerr  <= 1'b1;
                            err_q <= 1'b1;
                        end
                        if (RLAST_M) begin
                            RREADY_M <= 1'b0;
                            if (rerr || r_bad) begin
                                done  <= 1'b1;
                                state <= ST_FIN;
                            end else begin
                                AWADDR_M  <= dst;
                                AWLEN_M   <= ARLEN_M;
                                AWSIZE_M  <= AXI_SIZE_WORD;
                                AWBURST_M <= AXI_BURST_INCR;
                                AWVALID_M <= 1'b1;
                                state     <= ST_AW;
                            end
                        end
                    end
                end
                ST_AW: begin
                    if (AWREADY_M) begin
                        AWVALID_M <= 1'b0;
                        WVALID_M  <= 1'b1;
                        widx      <= '0;
                        state     <= ST_W;
                    end
                end
                ST_W: begin
                    if (WREADY_M) begin
                        if (w_last_beat) begin
                            WVALID_M <= 1'b0;
                            BREADY_M <= 1'b1;
                            state    <= ST_B;
                        end else begin
                            widx <= widx + idx_t'(1);
                        end
                    end
                end
                ST_B: begin
                    if (BVALID_M) begin
                        BREADY_M <= 1'b0;
                        src      <= src_nxt;
                        dst      <= dst_nxt;
                        rem      <= rem_nxt;
                        if (b_bad) begin
                            err_q <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else if (rem_nxt == 16'd0) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            beats     <= next_beats;
                            ridx      <= '0;
                            ARADDR_M  <= src_nxt;
                            ARLEN_M   <= len_t'(next_beats - 5'd1);
                            ARVALID_M <= 1'b1;
                            state     <= ST_AR;
                        end
                    end
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_m.sv
// Self-checking bench for dma_m: table of copy jobs plus hand-written
// reset and response-error sequences. A behavioural AXI slave answers the
// DUT; expected AR/AW bursts are queued when a job starts and popped as
// the DUT issues them.

`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

module tb_dma_m;

    localparam int DEPTH = 16;

    logic        ACLK;
    logic        ARESET;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_cnt;
    logic        busy;
    logic        done;
`ifdef DMA_M_RESP_CHECK_EN
    logic        err;
`endif
    logic [3:0]  ARID_M;
    logic [31:0] ARADDR_M;
    logic [7:0]  ARLEN_M;
    logic [2:0]  ARSIZE_M;
    logic [1:0]  ARBURST_M;
    logic        ARVALID_M;
    logic        ARREADY_M;
    logic [3:0]  RID_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M;
    logic        RLAST_M;
    logic        RVALID_M;
    logic        RREADY_M;
    logic [3:0]  AWID_M;
    logic [31:0] AWADDR_M;
    logic [7:0]  AWLEN_M;
    logic [2:0]  AWSIZE_M;
    logic [1:0]  AWBURST_M;
    logic        AWVALID_M;
    logic        AWREADY_M;
    logic [31:0] WDATA_M;
    logic [3:0]  WSTRB_M;
    logic        WLAST_M;
    logic        WVALID_M;
    logic        WREADY_M;
    logic [3:0]  BID_M;
    logic [1:0]  BRESP_M;
    logic        BVALID_M;
    logic        BREADY_M;

    dma_m #(.BUF_DEPTH(DEPTH), .M_ID(4'd0)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_cnt(word_cnt),
        .busy(busy), .done(done),
`ifdef DMA_M_RESP_CHECK_EN
        .err(err),
`endif
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M),
        .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M),
        .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M),
        .AWSIZE_M(AWSIZE_M), .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M),
        .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M),
        .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] cnt;
        int          nb;
        int          len0;
        bit          stall;
    } vec_t;

    int          errors = 0;
    int          n_checks = 0;
    burst_t      exp_ar[$];
    burst_t      exp_aw[$];
    burst_t      eb;
    logic [31:0] wmem [logic [31:0]];
    bit          stall_en = 0;
    bit          slv_rst = 1;
    int          ar_seen, aw_seen, done_seen, first_len;
    int          rbeat, inj_beat = -1;
    logic [31:0] r_addr, w_addr;
    int          r_left, w_left, b_pend;
    bit          r_held, b_held, ar_wait, aw_wait, w_wait;
    logic [39:0] ar_hold, aw_hold;
    logic [32:0] w_hold;
    vec_t        vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit go();
        return !stall_en || ($urandom_range(0, 2) == 0);
    endfunction

    // Behavioural AXI slave: decides its inputs on the falling edge, so every
    // handshake it accounts for here completes on the following rising edge.
    always @(negedge ACLK) begin
        if (slv_rst) begin
            ARREADY_M = 0; RVALID_M = 0; RLAST_M = 0; RDATA_M = 0; RRESP_M = 0; RID_M = 0;
            AWREADY_M = 0; WREADY_M = 0; BVALID_M = 0; BRESP_M = 0; BID_M = 0;
            r_left = 0; w_left = 0; b_pend = 0;
            r_held = 0; b_held = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
        end else begin
            if (done) done_seen++;
            // B
            if (!b_held) BVALID_M = (b_pend > 0) && go();
            b_held = 0;
            if (BVALID_M) begin
                if (BREADY_M) b_pend--;
                else b_held = 1;
            end
            // R
            if (!r_held) RVALID_M = (r_left > 0) && go();
            r_held = 0;
            RDATA_M = 0; RLAST_M = 0; RRESP_M = 0;
            if (RVALID_M) begin
                RDATA_M = pat(r_addr);
                RLAST_M = (r_left == 1);
                RRESP_M = (rbeat == inj_beat) ? 2'b10 : 2'b00;
                if (RREADY_M) begin
                    r_addr += 4; r_left--; rbeat++;
                end else r_held = 1;
            end
            // AR
            if (ar_wait) chk("ar_stable", {ARVALID_M, ARADDR_M, ARLEN_M}, {1'b1, ar_hold});
            ar_wait = 0;
            ARREADY_M = go();
            if (ARVALID_M && ARREADY_M) begin
                ar_seen++;
                if (ar_seen == 1) first_len = int'(ARLEN_M);
                if (exp_ar.size() == 0) fail("ar_unexpected");
                else begin
                    eb = exp_ar.pop_front();
                    chk("ar_addr", ARADDR_M, eb.addr);
                    chk("ar_len", ARLEN_M, eb.len);
                    chk("ar_size_burst", {ARSIZE_M, ARBURST_M}, 5'b010_01);
                end
                r_addr = ARADDR_M;
                r_left = int'(ARLEN_M) + 1;
            end else if (ARVALID_M) begin
                ar_wait = 1;
                ar_hold = {ARADDR_M, ARLEN_M};
            end
            // AW
            if (aw_wait) chk("aw_stable", {AWVALID_M, AWADDR_M, AWLEN_M}, {1'b1, aw_hold});
            aw_wait = 0;
            AWREADY_M = go();
            if (AWVALID_M && AWREADY_M) begin
                aw_seen++;
                if (exp_aw.size() == 0) fail("aw_unexpected");
                else begin
                    eb = exp_aw.pop_front();
                    chk("aw_addr", AWADDR_M, eb.addr);
                    chk("aw_len", AWLEN_M, eb.len);
                    chk("aw_size_burst", {AWSIZE_M, AWBURST_M}, 5'b010_01);
                end
                w_addr = AWADDR_M;
                w_left = int'(AWLEN_M) + 1;
            end else if (AWVALID_M) begin
                aw_wait = 1;
                aw_hold = {AWADDR_M, AWLEN_M};
            end
            // W
            if (w_wait) chk("w_stable", {WVALID_M, WLAST_M, WDATA_M}, {1'b1, w_hold});
            w_wait = 0;
            WREADY_M = go();
            if (WVALID_M && WREADY_M) begin
                chk("w_last", WLAST_M, (w_left == 1));
                chk("w_strb", WSTRB_M, 4'hF);
                wmem[w_addr] = WDATA_M;
                w_addr += 4;
                w_left--;
                if (w_left == 0) b_pend++;
            end else if (WVALID_M) begin
                w_wait = 1;
                w_hold = {WLAST_M, WDATA_M};
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_ctrl", {busy, done, ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M, WLAST_M}, 8'h00);
        chk("rst_addr", {ARADDR_M, AWADDR_M}, 64'h0);
        chk("rst_data", {WDATA_M, WSTRB_M, ARLEN_M, AWLEN_M}, 52'h0);
`ifdef DMA_M_RESP_CHECK_EN
        chk("rst_err", err, 1'b0);
`endif
    endtask

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] cnt,
                            input int exp_nb, input int exp_len0, input bit stall, input int inj);
        logic [31:0] s, d;
        int r, b, room, cyc, bad;
        s = {src[31:2], 2'b00};
        d = {dst[31:2], 2'b00};
        r = int'(cnt);
        while (r > 0) begin
            b = (r < DEPTH) ? r : DEPTH;
            room = (4096 - int'(s[11:0])) / 4;
            if (room < b) b = room;
            room = (4096 - int'(d[11:0])) / 4;
            if (room < b) b = room;
            exp_ar.push_back('{addr: s, len: 8'(b - 1)});
            if (inj >= 0) break;
            exp_aw.push_back('{addr: d, len: 8'(b - 1)});
            s += 32'(4 * b);
            d += 32'(4 * b);
            r -= b;
        end
        wmem.delete();
        ar_seen = 0; aw_seen = 0; done_seen = 0; first_len = -1;
        rbeat = 0; inj_beat = inj; stall_en = stall;

        @(negedge ACLK); #1;
        src_addr = src; dst_addr = dst; word_cnt = cnt; start = 1;
        @(negedge ACLK); #1;
        start = 0;
        chk("busy_rise", busy, 1'b1);
        if (cnt == 0) chk("done_next_cycle", done, 1'b1);
        else chk("arvalid_rise", ARVALID_M, 1'b1);

        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge ACLK); #1;
            cyc++;
        end
        if (cyc >= 5000) fail("done_timeout");
        chk("busy_with_done", busy, 1'b1);
        @(negedge ACLK); #1;
        chk("busy_fall", busy, 1'b0);
        chk("done_fall", done, 1'b0);
        chk("done_pulses", done_seen, 1);
        chk("ar_bursts", ar_seen, exp_nb);
        chk("aw_bursts", aw_seen, (inj >= 0) ? 0 : exp_nb);
        if (exp_nb > 0) chk("first_len", first_len, exp_len0);
        chk("ar_left", exp_ar.size(), 0);
        chk("aw_left", exp_aw.size(), 0);
        if (inj < 0) begin
            bad = 0;
            s = {src[31:2], 2'b00};
            d = {dst[31:2], 2'b00};
            for (int i = 0; i < int'(cnt); i++) begin
                if (!wmem.exists(d) || wmem[d] !== pat(s)) bad++;
                s += 4;
                d += 4;
            end
            chk("data_words_bad", bad, 0);
        end
`ifdef DMA_M_RESP_CHECK_EN
        chk("err_flag", err, (inj >= 0));
`endif
        exp_ar.delete();
        exp_aw.delete();
    endtask

    initial begin
        vecs[0] = '{src: 32'h0000_0100, dst: 32'h0001_0000, cnt: 16'd8,  nb: 1, len0: 7,  stall: 0};
        vecs[1] = '{src: 32'h0000_2000, dst: 32'h0000_3000, cnt: 16'd40, nb: 3, len0: 15, stall: 0};
        vecs[2] = '{src: 32'h0000_0FF8, dst: 32'h0000_8000, cnt: 16'd6,  nb: 2, len0: 1,  stall: 0};
        vecs[3] = '{src: 32'h0000_4004, dst: 32'h0000_9FF0, cnt: 16'd20, nb: 2, len0: 3,  stall: 1};
        vecs[4] = '{src: 32'h0000_0200, dst: 32'h0000_0300, cnt: 16'd0,  nb: 0, len0: 0,  stall: 0};
        vecs[5] = '{src: 32'h0000_5003, dst: 32'h0000_6002, cnt: 16'd17, nb: 2, len0: 15, stall: 1};

        ARESET = 1; start = 0; src_addr = 0; dst_addr = 0; word_cnt = 0;
        slv_rst = 1;
        repeat (3) @(negedge ACLK);
        #1;
        check_reset_outputs();
        ARESET = 0;
        slv_rst = 0;

        for (int i = 0; i < 6; i++) begin
            run_copy(vecs[i].src, vecs[i].dst, vecs[i].cnt, vecs[i].nb, vecs[i].len0, vecs[i].stall, -1);
        end

`ifdef DMA_M_RESP_CHECK_EN
        run_copy(32'h0000_0100, 32'h0000_0400, 16'd4, 1, 3, 0, 2);
`endif

        // Reset in the middle of a write burst.
        begin
            int cyc;
            exp_ar.push_back('{addr: 32'h0000_0100, len: 8'd15});
            exp_aw.push_back('{addr: 32'h0000_0800, len: 8'd15});
            stall_en = 0; inj_beat = -1;
            @(negedge ACLK); #1;
            src_addr = 32'h100; dst_addr = 32'h800; word_cnt = 16'd16; start = 1;
            @(negedge ACLK); #1;
            start = 0;
            cyc = 0;
            while (!WVALID_M && cyc < 2000) begin
                @(negedge ACLK); #1;
                cyc++;
            end
            if (cyc >= 2000) fail("wvalid_timeout");
            repeat (3) @(negedge ACLK);
            #1;
            ARESET = 1;
            slv_rst = 1;
            @(negedge ACLK); #1;
            check_reset_outputs();
            ARESET = 0;
            slv_rst = 0;
            exp_ar.delete();
            exp_aw.delete();
        end

        run_copy(32'h0000_0100, 32'h0000_0A00, 16'd12, 1, 11, 1, -1);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule
